// File: rtl/f2h_sdram_arb_pkg.sv
// Shared types and defaults for the f2h_sdram0 two-requester read arbiter.
package f2h_sdram_arb_pkg;

    localparam int unsigned ADDR_W_DEF  = 29;
    localparam int unsigned DATA_W_DEF  = 64;
    localparam int unsigned BURST_W_DEF = 8;

    // Requester indices as stored in the owner / last_owner registers
    localparam logic REQ_M0 = 1'b0;
    localparam logic REQ_M1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

endpackage

// File: rtl/f2h_sdram_read_arbiter.sv
// Round-robin arbiter giving two read masters whole-burst ownership of the
// HPS f2h_sdram0 Avalon-MM read port; returned beats are steered to the owner.
module f2h_sdram_read_arbiter
    import f2h_sdram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned BURST_W = BURST_W_DEF
) (
    input  logic               clk,
    input  logic               rst,

    input  logic [ADDR_W-1:0]  m0_address,
    input  logic [BURST_W-1:0] m0_burstcount,
    input  logic               m0_read,
    output logic               m0_waitrequest,
    output logic [DATA_W-1:0]  m0_readdata,
    output logic               m0_readdatavalid,

    input  logic [ADDR_W-1:0]  m1_address,
    input  logic [BURST_W-1:0] m1_burstcount,
    input  logic               m1_read,
    output logic               m1_waitrequest,
    output logic [DATA_W-1:0]  m1_readdata,
    output logic               m1_readdatavalid,

    output logic [ADDR_W-1:0]  sdram_address,
    output logic [BURST_W-1:0] sdram_burstcount,
    output logic               sdram_read,
    input  logic               sdram_waitrequest,
    input  logic [DATA_W-1:0]  sdram_readdata,
    input  logic               sdram_readdatavalid,

    output logic [1:0]         grant,
    output logic               err
);

    arb_state_e         state;
    logic               owner;
    logic               last_owner;
    logic [BURST_W-1:0] beat_cnt;

    logic [ADDR_W-1:0]  own_addr;
    logic [BURST_W-1:0] own_bc;
    logic               in_cmd;
    logic               in_data;
    logic               bc_zero;
    logic               fwd;
    logic               accept;
    logic               own_wait;
    logic               stray;
    logic               winner;

    // Owner command mux and handshake qualifiers
    always_comb begin
        own_addr = (owner == REQ_M1) ? m1_address    : m0_address;
        own_bc   = (owner == REQ_M1) ? m1_burstcount : m0_burstcount;
        in_cmd   = (state == ST_CMD);
        in_data  = (state == ST_DATA);
        bc_zero  = (own_bc == '0);
        fwd      = in_cmd && !bc_zero;
        accept   = fwd && !sdram_waitrequest;
        // A zero-length command is swallowed locally, so it is never stalled
        own_wait = bc_zero ? 1'b0 : sdram_waitrequest;
        stray    = sdram_readdatavalid && !in_data;
        // Tie goes to whoever did not own the port last; otherwise the lone requester
        winner   = (m0_read && m1_read) ? !last_owner : !m0_read;
    end

    // HPS-facing command: live only while a command is pending
    always_comb begin
        sdram_read       = fwd;
        sdram_address    = in_cmd ? own_addr : '0;
        sdram_burstcount = in_cmd ? own_bc   : '0;
    end

    // Requester-facing handshake and data steering; non-owner always stalled
    always_comb begin
        m0_waitrequest   = !(in_cmd && owner == REQ_M0) || own_wait;
        m1_waitrequest   = !(in_cmd && owner == REQ_M1) || own_wait;
        m0_readdatavalid = in_data && (owner == REQ_M0) && sdram_readdatavalid;
        m1_readdatavalid = in_data && (owner == REQ_M1) && sdram_readdatavalid;
        m0_readdata      = sdram_readdata;
        m1_readdata      = sdram_readdata;
    end

    // Burst ownership FSM with registered grant and error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            owner      <= REQ_M0;
            last_owner <= REQ_M1;
            beat_cnt   <= '0;
            grant      <= 2'b00;
            err        <= 1'b0;
        end else begin
            err <= stray || (in_cmd && bc_zero);
            case (state)
                ST_IDLE: begin
                    if (m0_read || m1_read) begin
                        owner <= winner;
                        grant <= (winner == REQ_M1) ? 2'b10 : 2'b01;
                        state <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (bc_zero) begin
                        last_owner <= owner;
                        grant      <= 2'b00;
                        state      <= ST_IDLE;
                    end else if (accept) begin
                        beat_cnt <= own_bc;
                        state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (sdram_readdatavalid) begin
                        beat_cnt <= beat_cnt - BURST_W'(1);
                        if (beat_cnt == BURST_W'(1)) begin
                            last_owner <= owner;
                            grant      <= 2'b00;
                            state      <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    grant <= 2'b00;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_f2h_sdram_read_arbiter.sv
// Self-checking bench for f2h_sdram_read_arbiter: HPS port model, beat scoreboard,
// table of single-requester bursts plus hand-written arbitration/error sequences.
module tb_f2h_sdram_read_arbiter;
    import f2h_sdram_arb_pkg::*;

    localparam int unsigned AW = 29;
    localparam int unsigned DW = 64;
    localparam int unsigned BW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] m0_address, m1_address;
    logic [BW-1:0] m0_burstcount, m1_burstcount;
    logic          m0_read, m1_read;
    logic          m0_waitrequest, m1_waitrequest;
    logic [DW-1:0] m0_readdata, m1_readdata;
    logic          m0_readdatavalid, m1_readdatavalid;
    logic [AW-1:0] sdram_address;
    logic [BW-1:0] sdram_burstcount;
    logic          sdram_read;
    logic          sdram_waitrequest;
    logic [DW-1:0] sdram_readdata;
    logic          sdram_readdatavalid;
    logic [1:0]    grant;
    logic          err;

    always #5 clk = ~clk;

    f2h_sdram_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .m0_address          (m0_address),
        .m0_burstcount       (m0_burstcount),
        .m0_read             (m0_read),
        .m0_waitrequest      (m0_waitrequest),
        .m0_readdata         (m0_readdata),
        .m0_readdatavalid    (m0_readdatavalid),
        .m1_address          (m1_address),
        .m1_burstcount       (m1_burstcount),
        .m1_read             (m1_read),
        .m1_waitrequest      (m1_waitrequest),
        .m1_readdata         (m1_readdata),
        .m1_readdatavalid    (m1_readdatavalid),
        .sdram_address       (sdram_address),
        .sdram_burstcount    (sdram_burstcount),
        .sdram_read          (sdram_read),
        .sdram_waitrequest   (sdram_waitrequest),
        .sdram_readdata      (sdram_readdata),
        .sdram_readdatavalid (sdram_readdatavalid),
        .grant               (grant),
        .err                 (err)
    );

    typedef struct {
        logic [1:0]    who;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct {
        string         tag;
        logic          who;      // requester driving the burst
        logic [AW-1:0] addr;
        logic [BW-1:0] bc;
        int            waitc;    // cycles the HPS stalls the command (>=1)
        int            gap;      // idle cycles before each beat
        logic [1:0]    exp_grant;
    } vec_t;

    beat_t sbq[$];
    beat_t mon_e;
    int    n_cmp    = 0;
    int    n_bad    = 0;
    int    err_cnt  = 0;
    int    m0_beats = 0;
    int    m1_beats = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    function automatic logic wr_of(input logic [1:0] g);
        return g[0] ? m0_waitrequest : m1_waitrequest;
    endfunction

    function automatic logic wr_other(input logic [1:0] g);
        return g[0] ? m1_waitrequest : m0_waitrequest;
    endfunction

    // Scoreboard consumer: every beat a requester sees must match the next expected one
    always @(negedge clk) begin
        if (err === 1'b1) err_cnt++;
        if (m0_readdatavalid === 1'b1 || m1_readdatavalid === 1'b1) begin
            if (m0_readdatavalid === 1'b1) m0_beats++;
            if (m1_readdatavalid === 1'b1) m1_beats++;
            if (sbq.size() == 0) begin
                check("unexpected_beat", 64'({m1_readdatavalid, m0_readdatavalid}), 64'(0));
            end else begin
                mon_e = sbq.pop_front();
                check("beat_owner", 64'({m1_readdatavalid, m0_readdatavalid}), 64'(mon_e.who));
                check("beat_data_m0", m0_readdata, mon_e.data);
                check("beat_data_m1", m1_readdata, mon_e.data);
            end
        end
    end

    // HPS side of one burst: wait for the command, stall, accept, return beats
    task automatic serve(input string tag, input logic [1:0] g, input logic [AW-1:0] a,
                         input logic [BW-1:0] bc, input int waitc, input int gap,
                         input int lat, input bit hold);
        int t;
        int b0;
        int b1;
        b0 = m0_beats;
        b1 = m1_beats;
        t  = 0;
        smp();
        while (sdram_read !== 1'b1 && t < 60) begin
            smp();
            t++;
        end
        check({tag, "_cmd_latency"}, 64'(t), 64'(lat));
        check({tag, "_grant"}, 64'(grant), 64'(g));
        check({tag, "_addr"}, 64'(sdram_address), 64'(a));
        check({tag, "_bc"}, 64'(sdram_burstcount), 64'(bc));
        for (int k = 0; k < waitc; k++) begin
            check({tag, "_stall_wr"}, 64'(wr_of(g)), 64'(1));
            check({tag, "_other_wr"}, 64'(wr_other(g)), 64'(1));
            if (k < waitc - 1) begin
                cyc();
                smp();
                check({tag, "_addr_held"}, 64'(sdram_address), 64'(a));
                check({tag, "_bc_held"}, 64'(sdram_burstcount), 64'(bc));
            end
        end
        cyc();
        sdram_waitrequest = 1'b0;
        smp();
        check({tag, "_accept_wr"}, 64'(wr_of(g)), 64'(0));
        check({tag, "_accept_other_wr"}, 64'(wr_other(g)), 64'(1));
        check({tag, "_accept_read"}, 64'(sdram_read), 64'(1));
        cyc();
        sdram_waitrequest = 1'b1;
        if (!hold) begin
            if (g[0]) m0_read = 1'b0;
            else      m1_read = 1'b0;
        end
        for (int b = 0; b < int'(bc); b++) begin
            for (int q = 0; q < gap; q++) begin
                sdram_readdatavalid = 1'b0;
                cyc();
            end
            sdram_readdatavalid = 1'b1;
            sdram_readdata      = {$urandom, $urandom};
            sbq.push_back('{who: g, data: sdram_readdata});
            cyc();
        end
        sdram_readdatavalid = 1'b0;
        smp();
        check({tag, "_idle_grant"}, 64'(grant), 64'(0));
        check({tag, "_idle_read"}, 64'(sdram_read), 64'(0));
        check({tag, "_idle_addr"}, 64'(sdram_address), 64'(0));
        check({tag, "_idle_bc"}, 64'(sdram_burstcount), 64'(0));
        check({tag, "_sb_drained"}, 64'(sbq.size()), 64'(0));
        check({tag, "_owner_beats"}, 64'(g[0] ? m0_beats - b0 : m1_beats - b1), 64'(bc));
        check({tag, "_other_beats"}, 64'(g[0] ? m1_beats - b1 : m0_beats - b0), 64'(0));
    endtask

    task automatic request(input logic who, input logic [AW-1:0] a, input logic [BW-1:0] bc);
        if (who == REQ_M1) begin
            m1_address = a; m1_burstcount = bc; m1_read = 1'b1;
        end else begin
            m0_address = a; m0_burstcount = bc; m0_read = 1'b1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int   ec;
        int   b0;

        vecs[0] = '{"v_m0_0x100", REQ_M0, 29'h100,       8'd4,   2, 0, 2'b01};
        vecs[1] = '{"v_m1_mid",   REQ_M1, 29'h0ABCDEF,   8'd3,   1, 0, 2'b10};
        vecs[2] = '{"v_m0_top",   REQ_M0, 29'h1FFFFFFF,  8'd1,   1, 2, 2'b01};
        vecs[3] = '{"v_m1_zero",  REQ_M1, 29'h0,         8'd16,  4, 1, 2'b10};
        vecs[4] = '{"v_m1_255",   REQ_M1, 29'h1555555,   8'd255, 1, 0, 2'b10};

        rst = 1'b1;
        m0_address = '0; m1_address = '0;
        m0_burstcount = '0; m1_burstcount = '0;
        m0_read = 1'b0; m1_read = 1'b0;
        sdram_waitrequest = 1'b1;
        sdram_readdata = '0;
        sdram_readdatavalid = 1'b0;
        repeat (2) cyc();
        smp();
        check("rst_grant", 64'(grant), 64'(0));
        check("rst_m0_wr", 64'(m0_waitrequest), 64'(1));
        check("rst_m1_wr", 64'(m1_waitrequest), 64'(1));
        check("rst_rdv", 64'({m1_readdatavalid, m0_readdatavalid}), 64'(0));
        check("rst_sdram_read", 64'(sdram_read), 64'(0));
        check("rst_sdram_addr", 64'(sdram_address), 64'(0));
        check("rst_sdram_bc", 64'(sdram_burstcount), 64'(0));
        check("rst_err", 64'(err), 64'(0));

        // Tie straight out of reset: m0 first, one bubble, then m1
        cyc();
        rst = 1'b0;
        request(REQ_M0, 29'h0000AA0, 8'd2);
        request(REQ_M1, 29'h0000BB0, 8'd2);
        serve("tie_m0", 2'b01, 29'h0000AA0, 8'd2, 1, 0, 1, 1'b0);
        serve("tie_m1", 2'b10, 29'h0000BB0, 8'd2, 1, 0, 0, 1'b0);

        // Single-requester table
        ec = err_cnt;
        foreach (vecs[i]) begin
            cyc();
            request(vecs[i].who, vecs[i].addr, vecs[i].bc);
            serve(vecs[i].tag, vecs[i].exp_grant, vecs[i].addr, vecs[i].bc,
                  vecs[i].waitc, vecs[i].gap, 1, 1'b0);
        end
        check("table_no_err", 64'(err_cnt - ec), 64'(0));

        // m0 requests back to back, m1 once: m0, m1, m0
        cyc();
        request(REQ_M0, 29'h200, 8'd2);
        cyc();
        request(REQ_M1, 29'h210, 8'd3);
        serve("rr_m0a", 2'b01, 29'h200, 8'd2, 1, 0, 0, 1'b1);
        serve("rr_m1",  2'b10, 29'h210, 8'd3, 1, 0, 0, 1'b0);
        serve("rr_m0b", 2'b01, 29'h200, 8'd2, 1, 0, 0, 1'b0);

        // Zero-length burst from m1: consumed locally, err once, m1 becomes last owner
        cyc();
        ec = err_cnt;
        request(REQ_M1, 29'h55, 8'd0);
        smp();
        smp();
        check("b0_grant", 64'(grant), 64'(2'b10));
        check("b0_no_read", 64'(sdram_read), 64'(0));
        check("b0_m1_wr", 64'(m1_waitrequest), 64'(0));
        check("b0_m0_wr", 64'(m0_waitrequest), 64'(1));
        cyc();
        m1_read = 1'b0;
        smp();
        check("b0_idle_grant", 64'(grant), 64'(0));
        check("b0_m1_wr_back", 64'(m1_waitrequest), 64'(1));
        check("b0_err", 64'(err), 64'(1));
        cyc();
        smp();
        check("b0_err_clear", 64'(err), 64'(0));
        check("b0_err_count", 64'(err_cnt - ec), 64'(1));
        cyc();
        request(REQ_M0, 29'h400, 8'd3);
        request(REQ_M1, 29'h500, 8'd2);
        serve("b0_next_m0", 2'b01, 29'h400, 8'd3, 1, 0, 1, 1'b0);
        serve("b0_next_m1", 2'b10, 29'h500, 8'd2, 2, 1, 0, 1'b0);

        // Reset after 2 of 8 beats; the remaining 6 are strays
        cyc();
        b0 = m0_beats;
        request(REQ_M0, 29'h300, 8'd8);
        smp();
        smp();
        check("mr_grant", 64'(grant), 64'(2'b01));
        check("mr_read", 64'(sdram_read), 64'(1));
        cyc();
        sdram_waitrequest = 1'b0;
        smp();
        check("mr_accept_wr", 64'(m0_waitrequest), 64'(0));
        cyc();
        sdram_waitrequest = 1'b1;
        m0_read = 1'b0;
        for (int b = 0; b < 2; b++) begin
            sdram_readdatavalid = 1'b1;
            sdram_readdata      = {$urandom, $urandom};
            sbq.push_back('{who: 2'b01, data: sdram_readdata});
            cyc();
        end
        sdram_readdatavalid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        ec = err_cnt;
        smp();
        check("mr_idle_grant", 64'(grant), 64'(0));
        check("mr_idle_read", 64'(sdram_read), 64'(0));
        check("mr_idle_m0_wr", 64'(m0_waitrequest), 64'(1));
        for (int b = 0; b < 6; b++) begin
            cyc();
            sdram_readdatavalid = 1'b1;
            sdram_readdata      = {$urandom, $urandom};
        end
        cyc();
        sdram_readdatavalid = 1'b0;
        cyc();
        smp();
        check("mr_stray_err_count", 64'(err_cnt - ec), 64'(6));
        check("mr_m0_beats", 64'(m0_beats - b0), 64'(2));
        check("mr_sb_drained", 64'(sbq.size()), 64'(0));
        cyc();
        request(REQ_M1, 29'h0ABC, 8'd1);
        serve("mr_fresh_m1", 2'b10, 29'h0ABC, 8'd1, 1, 0, 1, 1'b0);

        // Longest power-of-two burst with every-other-cycle data
        cyc();
        ec = err_cnt;
        request(REQ_M0, 29'h7FF, 8'd128);
        serve("b128", 2'b01, 29'h7FF, 8'd128, 1, 1, 1, 1'b0);
        cyc();
        smp();
        check("b128_no_err", 64'(err_cnt - ec), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/f2h_sdram_read_arbiter.md
# f2h_sdram_read_arbiter

Two-requester round-robin arbiter sharing the single HPS f2h_sdram0 Avalon-MM burst-read port between FPGA-side read masters, such as the existing SDRAM read tester and a second DMA-style reader. It owns the port for one whole burst at a time: it grants, forwards the command, then steers every returned data beat to the owning requester before re-arbitrating. All logic runs in the f2h_sdram0 clock domain (FPGA_CLK1_50).

## Interface
Parameters:
- ADDR_W, 29, word address width (64-bit words)
- DATA_W, 64, read data width
- BURST_W, 8, burstcount width

Ports (m0/m1 are the requester-facing slave ports; sdram_* faces the HPS):
- clk  in  1  port clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- m0_address, m1_address  in  ADDR_W  requester word address
- m0_burstcount, m1_burstcount  in  BURST_W  beats requested
- m0_read, m1_read  in  1  read request, held until accepted
- m0_waitrequest, m1_waitrequest  out  1  command not accepted
- m0_readdata, m1_readdata  out  DATA_W  broadcast copy of sdram_readdata
- m0_readdatavalid, m1_readdatavalid  out  1  beat valid for this requester only
- sdram_address  out  ADDR_W  to hps_0_f2h_sdram0_data_address
- sdram_burstcount  out  BURST_W  to hps_0_f2h_sdram0_data_burstcount
- sdram_read  out  1  to hps_0_f2h_sdram0_data_read
- sdram_waitrequest  in  1  from HPS
- sdram_readdata  in  DATA_W  from HPS
- sdram_readdatavalid  in  1  from HPS
- grant  out  2  one-hot current owner; 00 when idle
- err  out  1  one-cycle pulse on a protocol violation

## Operation
- FSM states: IDLE, CMD, DATA. One burst is outstanding at most.
- IDLE: the arbiter samples m0_read and m1_read.
  - One requester asserted: that requester wins.
  - Both asserted: the requester not recorded in last_owner wins.
  - The winner is registered as owner, and the FSM moves to CMD.
- CMD:
  - The owner's address, burstcount and read are driven combinationally onto sdram_*.
  - The owner's waitrequest equals sdram_waitrequest.
  - On sdram_read && !sdram_waitrequest, beat_cnt loads burstcount and the FSM moves to DATA.
- Burstcount 0 in CMD:
  - The arbiter does not forward it (sdram_read stays 0).
  - The owner's waitrequest drops for 1 cycle so the command is consumed.
  - err pulses, and the FSM returns to IDLE. last_owner is updated.
- DATA:
  - Each sdram_readdatavalid is routed to the owner's readdatavalid and decrements beat_cnt.
  - The beat with beat_cnt==1 is the last beat. The FSM moves to IDLE and last_owner takes the owner's value.
- Non-owner: waitrequest is held at 1 and readdatavalid at 0 in every state.
- sdram_* outputs are 0 outside CMD.
- sdram_readdatavalid in IDLE or CMD is a stray beat: it is dropped (no requester sees it) and err pulses.
- A requester that deasserts read in CMD is a protocol violation. The command is forwarded anyway (the Avalon master must hold it), and no recovery is attempted.
- beat_cnt is BURST_W bits wide and counts down only. It never underflows, because DATA exits at 1.

## Timing
- Reset values:
  - state=IDLE, grant=00, beat_cnt=0, last_owner=1 (so m0 wins the first tie).
  - m*_waitrequest=1, m*_readdatavalid=0, sdram_read=0, sdram_address=0, sdram_burstcount=0, err=0.
- Request latency: m0_read rises at cycle N in IDLE. grant and sdram_read are 1 at cycle N+1.
- Accept: the requester sees waitrequest=0 in the same cycle the HPS accepts. This is zero-cycle pass-through.
- readdatavalid to requester: combinational, zero added latency.
- Re-arbitration: the last beat at cycle M gives IDLE at M+1. The next sdram_read is at M+2, a 1-cycle bubble.
- rst mid-burst: next cycle is IDLE. Remaining HPS beats arrive as strays and are dropped with err. The integrator holds the HPS in reset alongside, via hps_cold_reset.
- Simultaneous last beat and new requests: the new requests are evaluated in IDLE at M+1 using the updated last_owner.

## Structure
- Shared package f2h_sdram_arb_pkg holds:
  - the state enum (IDLE/CMD/DATA);
  - the ADDR_W/DATA_W/BURST_W defaults;
  - the requester index constants.
- Single module with no sub-module. The arbitration decision is a few gates and is written inline.

## Test plan
- m0 only, addr 0x100, burst 4, HPS wait 2 cycles -> sdram_address 0x100 and burstcount 4 held through the wait; m0 gets exactly 4 readdatavalid; m1 gets 0; grant 01 then 00.
- m0 and m1 both request from reset, burst 2 each -> m0 is served first and m1 second; grant sequence 01, 00, 10, 00; one idle cycle between bursts.
- m0 requests continuously, m1 requests once -> order m0, m1, m0 with no starvation; m1 is served after at most one m0 burst.
- m1 burst 0 -> no sdram_read; m1_waitrequest low for 1 cycle; err pulses once; next grant proceeds normally.
- rst asserted after beat 2 of an 8-beat m0 burst, 6 beats still arriving -> IDLE the next cycle; no requester readdatavalid; err pulses on each stray beat; then a fresh m1 burst 1 completes correctly.
- burst 128 with gapped readdatavalid (every other cycle) -> exactly 128 beats reach the owner and the FSM leaves DATA on the 128th.
